mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares one single-port memory bus between the rv32i_core instruction-fetch port and its load/store port. It captures one request at a time, drives the downstream bus with a req/gnt/rvalid handshake and routes read data back to the owning requester. It sits between the core and the unified SRAM/flash controller, with one outstanding transaction.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; `DATA_W/8` strobe bits.

Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.

Instruction-fetch requester:
- `if_req` in 1: fetch request. Held with `if_addr` stable until `if_gnt`.
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: request accepted this cycle.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` out DATA_W: fetch data.

Data (load/store) requester:
- `d_req` in 1: data request. Held stable until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_wstrb` in DATA_W/8: byte strobes.
- `d_gnt` out 1: request accepted.
- `d_rvalid` out 1: load data pulse. Never asserted for stores.
- `d_rdata` out DATA_W: load data.

Memory bus:
- `mem_req` out 1: request. Held with all fields stable until `mem_gnt`.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` out: registered command fields.
- `mem_gnt` in 1: memory accepts the command.
- `mem_rvalid` in 1: read data valid. Arrives at least 1 cycle after `mem_gnt`.
- `mem_rdata` in DATA_W: read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - If any request is pending, select a winner. Assert its `*_gnt` combinationally in the same cycle.
  - Register the winner's address, write data, strobe and write flag into the command register. Record `owner`.
  - Next state is ISSUE.
- **ISSUE**
  - `mem_req` is 1.
  - On `mem_gnt`: a store goes to IDLE; a load goes to WAIT.
- **WAIT**
  - On `mem_rvalid`: register `mem_rdata` into a shared `rdata` register, pulse the owner's `*_rvalid` next cycle, and return to IDLE.
- Arbitration (default): data port has fixed priority. Fetch starves while `d_req` stays high; this is an accepted trade-off.
- At most one `*_gnt` is high in any cycle. No grant is given outside IDLE.
- `mem_gnt` outside ISSUE and `mem_rvalid` outside WAIT are ignored, with no state change.
- `if_rdata` and `d_rdata` both show the shared `rdata` register. It holds its last value between transactions; only the matching `*_rvalid` qualifies it.
- Reset values: FSM = IDLE and `owner` = data. `mem_req`, `mem_we`, all `*_gnt` and all `*_rvalid` are 0. The command register and `rdata` are 0.
- Reset mid-transaction: the transaction is abandoned and `mem_req` drops asynchronously. A late `mem_rvalid` after reset is ignored.

## Timing
- Request seen in IDLE at cycle N:
  - `*_gnt` is high at N.
  - `mem_req` is high from N+1.
- `mem_gnt` at cycle M:
  - Store: IDLE at M+1, so the next grant can come at M+1.
  - Load: WAIT from M+1.
- `mem_rvalid` at cycle K: `*_rvalid` and data at K+1, and IDLE at K+1.
- Back-to-back loads with 0-wait memory (`mem_gnt` at N+1, `mem_rvalid` at N+2): one transaction every 3 cycles.
- `*_gnt` is a combinational function of FSM state, the `*_req` inputs and `owner`. The `mem_*` outputs are registered only.

## Configuration
- `ARB_RR_EN` defined: round-robin arbitration.
  - When both requests are high in IDLE, grant the requester that is not the last recorded `owner`.
  - `owner` resets to data, so fetch wins the first contended cycle.
  - Single requests are granted immediately regardless of `owner`.
- `ARB_RR_EN` undefined: fixed data-port priority as described in Operation.

## Test plan
- Single fetch:
  - Stimulus: `if_req`=1, `if_addr`=0x100; `mem_gnt` 1 cycle later; `mem_rvalid`=1 with 0x00500093 two cycles later.
  - Required: `if_gnt` at N, `mem_addr`=0x100 with `mem_we`=0, `if_rvalid`=1 with `if_rdata`=0x00500093 exactly one cycle after `mem_rvalid`, and `d_rvalid` stays 0.
- Store:
  - Stimulus: `d_req`=1, `d_we`=1, `d_addr`=0x2000, `d_wdata`=0xDEADBEEF, `d_wstrb`=0xF.
  - Required: the bus shows those values with `mem_we`=1 until `mem_gnt`. No `d_rvalid`. The next grant is possible the cycle after `mem_gnt`.
- Contention with `ARB_RR_EN` undefined:
  - Stimulus: both requests high for 3 transactions.
  - Required: `d_gnt` 3 times and `if_gnt` never.
- Contention with `ARB_RR_EN` defined:
  - Stimulus: same as the previous scenario.
  - Required: grants alternate IF, D, IF.
- Memory stall:
  - Stimulus: `mem_gnt` withheld for 5 cycles.
  - Required: `mem_req` and all `mem_*` fields stay constant, and there are no new grants.
- Reset in WAIT:
  - Stimulus: drop `rst_n` while a load is in WAIT, release it, then pulse `mem_rvalid`.
  - Required: `mem_req`=0 immediately and no `*_rvalid`. A fresh `if_req` is granted normally afterwards.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between the instruction
// fetch port and the load/store port of the core, one transaction in flight.
// The selected command is captured into a registered command register that
// drives the memory bus; read data returns through one shared rdata register.
// Optional feature: define ARB_RR_EN for round-robin arbitration; the default
// build gives the data port fixed priority over fetch.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,

  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_fetch_q, owner_fetch_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic                  if_win;
  logic                  d_win;

  // Pick at most one winner, and only while idle; grants are combinational.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (state_q == IDLE) begin
`ifdef ARB_RR_EN
      if (if_req && d_req) begin
        if (owner_fetch_q) begin
          d_win = 1'b1;
        end else begin
          if_win = 1'b1;
        end
      end else begin
        if_win = if_req;
        d_win  = d_req;
      end
`else
      d_win  = d_req;
      if_win = if_req && !d_req;
`endif
    end
  end

  // Next-state, command capture and read-data return for the three-state FSM.
  always_comb begin
    state_d       = state_q;
    owner_fetch_d = owner_fetch_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rdata_d       = rdata_q;
    if_rvalid_d   = 1'b0;
    d_rvalid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_win) begin
          state_d       = ISSUE;
          owner_fetch_d = 1'b0;
          req_d         = 1'b1;
          we_d          = d_we;
          addr_d        = d_addr;
          wdata_d       = d_wdata;
          wstrb_d       = d_wstrb;
        end else if (if_win) begin
          state_d       = ISSUE;
          owner_fetch_d = 1'b1;
          req_d         = 1'b1;
          we_d          = 1'b0;
          addr_d        = if_addr;
          wdata_d       = '0;
          wstrb_d       = '0;
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          req_d   = 1'b0;
          state_d = we_q ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          rdata_d     = mem_rdata;
          if_rvalid_d = owner_fetch_q;
          d_rvalid_d  = !owner_fetch_q;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_fetch_q <= 1'b0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rdata_q       <= '0;
      if_rvalid_q   <= 1'b0;
      d_rvalid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_fetch_q <= owner_fetch_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rdata_q       <= rdata_d;
      if_rvalid_q   <= if_rvalid_d;
      d_rvalid_q    <= d_rvalid_d;
    end
  end

  assign if_gnt    = if_win;
  assign d_gnt     = d_win;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = rdata_q;
  assign d_rdata   = rdata_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: randomized requesters, a memory responder
// with its own storage, and a scoreboard of expected bus commands and read
// responses produced by a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        isFetch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  typedef struct packed {
    logic        isFetch;
    logic [31:0] data;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int rvalidCycle = 0;
  int rvalidSeen = 0;
  int expectMemReqCycle = -1;
  int idleWait = 0;
  int nextStall = -1;
  bit stallForever = 0;
  bit holdRvalid = 0;
  bit forceRvalid = 0;
  bit randomOn = 0;
  bit forceBoth = 0;
  bit ifPend = 0;
  bit dPend = 0;
  bit lastOwnerFetch = 0;

  cmd_t        cmdQ[$];
  rsp_t        rspQ[$];
  bit          winLog[$];
  logic [31:0] refMem[logic [31:0]];
  logic [31:0] bfmMem[logic [31:0]];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic failNow(input string name, input string what);
    total++;
    bad++;
    $display("[TB] FAIL %s actual=%s (cycle %0d)", name, what, cycle);
  endtask

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] data,
                                            input logic [3:0] strb);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
    end
    return w;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (refMem.exists(a)) return refMem[a];
    return initWord(a);
  endfunction

  function automatic logic [31:0] bfmRead(input logic [31:0] a);
    if (bfmMem.exists(a)) return bfmMem[a];
    return initWord(a);
  endfunction

  function automatic logic [31:0] pickAddr();
    logic [31:0] pool [6];
    pool[0] = 32'h100;  pool[1] = 32'h104;  pool[2] = 32'h2000;
    pool[3] = 32'h2004; pool[4] = 32'h3000; pool[5] = 32'h3FFC;
    return pool[$urandom_range(0, 5)];
  endfunction

  task automatic raiseFetch(input logic [31:0] a);
    if_addr = a;
    if_req  = 1;
    ifPend  = 1;
  endtask

  task automatic raiseData(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws);
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_wstrb = ws;
    d_req   = 1;
    dPend   = 1;
  endtask

  // Memory responder: grants after a programmable stall, returns loads after
  // 1..3 cycles from its own storage, and sprinkles ignored handshake pulses.
  initial begin
    int   rvCount;
    int   stallCnt;
    logic [31:0] pendAddr;
    cmd_t c;
    rvCount = 0;
    stallCnt = -1;
    pendAddr = 0;
    mem_gnt = 0;
    mem_rvalid = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_gnt = 0;
      mem_rvalid = 0;
      if (!rst_n) begin
        rvCount = 0;
        stallCnt = -1;
        continue;
      end
      if (rvCount > 0) begin
        if (!holdRvalid) rvCount--;
        if (rvCount == 0) begin
          mem_rvalid = 1;
          mem_rdata = bfmRead(pendAddr);
          rvalidCycle = cycle;
        end else if ($urandom_range(0, 3) == 0) begin
          mem_gnt = 1;
        end
      end else if (mem_req) begin
        if (cmdQ.size() == 0) begin
          failNow("unexpected_mem_req", "mem_req with no granted command");
        end else begin
          c = cmdQ[0];
          checkOutput("mem_we", mem_we, c.we);
          checkOutput("mem_addr", mem_addr, c.addr);
          if (c.we) begin
            checkOutput("mem_wdata", mem_wdata, c.wdata);
            checkOutput("mem_wstrb", mem_wstrb, c.wstrb);
          end
          if (stallCnt < 0) begin
            stallCnt = (nextStall >= 0) ? nextStall : $urandom_range(0, 2);
            nextStall = -1;
          end
          if (stallForever) begin
            stallCnt = 1;
          end else if (stallCnt > 0) begin
            stallCnt--;
          end else begin
            mem_gnt = 1;
            stallCnt = -1;
            void'(cmdQ.pop_front());
            if (mem_we) begin
              bfmMem[mem_addr] = mergeWord(bfmRead(mem_addr), mem_wdata, mem_wstrb);
            end else begin
              pendAddr = mem_addr;
              rvCount = $urandom_range(1, 3);
            end
          end
        end
      end else if (forceRvalid || $urandom_range(0, 7) == 0) begin
        forceRvalid = 0;
        mem_rvalid = 1;
        mem_rdata = $urandom;
      end
    end
  end

  // Response monitor: every read pulse must match the oldest expected response.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (if_gnt || d_gnt) checkOutput("gnt_onehot", if_gnt && d_gnt, 0);
      if (if_rvalid || d_rvalid) begin
        rvalidSeen++;
        checkOutput("rvalid_onehot", if_rvalid && d_rvalid, 0);
        if (rspQ.size() == 0) begin
          failNow("unexpected_rvalid", $sformatf("if_rvalid=%0b d_rvalid=%0b required none",
                                                 if_rvalid, d_rvalid));
        end else begin
          e = rspQ.pop_front();
          checkOutput("rvalid_owner", if_rvalid, e.isFetch);
          checkOutput("rdata", e.isFetch ? if_rdata : d_rdata, e.data);
          checkOutput("rvalid_latency", cycle, rvalidCycle + 1);
        end
      end
    end
  end

  // One clock of requester activity: grant checking against the model, then
  // dropping served requests and raising new ones.
  task automatic applyStimulus();
    bit gotFetch;
    bit expFetch;
    @(negedge clk);
    #1;
    if (expectMemReqCycle == cycle) checkOutput("mem_req_after_gnt", mem_req, 1);
    if (if_gnt || d_gnt) begin
      idleWait = 0;
      gotFetch = if_gnt && !d_gnt;
      if (!ifPend && !dPend) begin
        failNow("spurious_grant", "grant with no request pending");
      end else begin
`ifdef ARB_RR_EN
        if (ifPend && dPend) expFetch = !lastOwnerFetch;
        else expFetch = ifPend;
`else
        expFetch = !dPend;
`endif
        checkOutput("grant_winner", gotFetch, expFetch);
        checkOutput("grant_while_busy", cmdQ.size() + rspQ.size(), 0);
        if (gotFetch && ifPend) begin
          cmdQ.push_back('{1'b1, 1'b0, if_addr, 32'd0, 4'd0});
          rspQ.push_back('{1'b1, refRead(if_addr)});
          ifPend = 0;
        end else if (!gotFetch && dPend) begin
          cmdQ.push_back('{1'b0, d_we, d_addr, d_wdata, d_wstrb});
          if (d_we) refMem[d_addr] = mergeWord(refRead(d_addr), d_wdata, d_wstrb);
          else rspQ.push_back('{1'b0, refRead(d_addr)});
          dPend = 0;
        end
        lastOwnerFetch = gotFetch;
        winLog.push_back(gotFetch);
        expectMemReqCycle = cycle + 1;
      end
    end else if (ifPend || dPend) begin
      idleWait++;
      if (idleWait > 60) begin
        failNow("grant_timeout", "no grant within 60 cycles");
        ifPend = 0;
        dPend = 0;
        idleWait = 0;
      end
    end
    @(posedge clk);
    #1;
    if (!ifPend) if_req = 0;
    if (!dPend) d_req = 0;
    if (!ifPend && (forceBoth || (randomOn && $urandom_range(0, 2) == 0))) raiseFetch(pickAddr());
    if (!dPend && (forceBoth || (randomOn && $urandom_range(0, 2) == 0)))
      raiseData(1'($urandom_range(0, 1)), pickAddr(), $urandom, 4'($urandom_range(1, 15)));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((ifPend || dPend || cmdQ.size() != 0 || rspQ.size() != 0) && n < 300) begin
      applyStimulus();
      n++;
    end
    if (n >= 300) failNow("drain_timeout", "transactions still outstanding");
  endtask

  task automatic resetCleanup();
    if_req = 0;
    d_req = 0;
    ifPend = 0;
    dPend = 0;
    cmdQ.delete();
    rspQ.delete();
    lastOwnerFetch = 0;
    stallForever = 0;
    holdRvalid = 0;
    idleWait = 0;
    expectMemReqCycle = -1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    int n;
    int seenBefore;
    logic [2:0] expSeq;
    rst_n = 0;
    if_req = 0;
    if_addr = 0;
    d_req = 0;
    d_we = 0;
    d_addr = 0;
    d_wdata = 0;
    d_wstrb = 0;
    refMem[32'h100] = 32'h00500093;
    bfmMem[32'h100] = 32'h00500093;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_mem_wstrb", mem_wstrb, 0);
    checkOutput("rst_rvalids", {if_rvalid, d_rvalid}, 0);
    checkOutput("rst_rdata", if_rdata | d_rdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // Single fetch with immediate memory.
    nextStall = 0;
    raiseFetch(32'h100);
    drain();

    // Store held through a five-cycle stall, with a fetch waiting behind it.
    nextStall = 5;
    raiseData(1'b1, 32'h2000, 32'hDEADBEEF, 4'hF);
    repeat (2) applyStimulus();
    raiseFetch(32'h2000);
    drain();
    raiseData(1'b0, 32'h3000, 32'h0, 4'h0);
    drain();

    // Contention: both ports keep requesting for three transactions.
    winLog.delete();
    forceBoth = 1;
    raiseFetch(pickAddr());
    raiseData(1'b0, pickAddr(), 32'h0, 4'h0);
    n = 0;
    while (winLog.size() < 3 && n < 100) begin
      applyStimulus();
      n++;
    end
    forceBoth = 0;
`ifdef ARB_RR_EN
    expSeq = 3'b101;
`else
    expSeq = 3'b000;
`endif
    if (winLog.size() < 3) begin
      failNow("contention_grants", "fewer than 3 grants");
    end else begin
      for (int i = 0; i < 3; i++) checkOutput($sformatf("contention_win%0d_isfetch", i), winLog[i], expSeq[2-i]);
    end
    drain();

    // Randomized traffic.
    randomOn = 1;
    repeat (600) applyStimulus();
    randomOn = 0;
    drain();

    // Reset while a command is stalled on the bus.
    stallForever = 1;
    raiseFetch(32'h104);
    repeat (3) applyStimulus();
    checkOutput("stalled_mem_req", mem_req, 1);
    #2;
    rst_n = 0;
    #1;
    checkOutput("rst_issue_mem_req", mem_req, 0);
    checkOutput("rst_issue_mem_addr", mem_addr, 0);
    resetCleanup();

    // Reset while a load waits for data, then a late read pulse.
    holdRvalid = 1;
    raiseFetch(32'h100);
    n = 0;
    while (!(cmdQ.size() == 0 && rspQ.size() == 1 && !ifPend) && n < 30) begin
      applyStimulus();
      n++;
    end
    checkOutput("wait_reached_rsp_pending", rspQ.size(), 1);
    repeat (2) applyStimulus();
    #2;
    rst_n = 0;
    #1;
    checkOutput("rst_wait_mem_req", mem_req, 0);
    checkOutput("rst_wait_rvalids", {if_rvalid, d_rvalid}, 0);
    resetCleanup();
    seenBefore = rvalidSeen;
    forceRvalid = 1;
    repeat (4) applyStimulus();
    checkOutput("late_rvalid_ignored", rvalidSeen - seenBefore, 0);
    raiseFetch(32'h2000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
